// File: rtl/spi_facade.sv
// SPI master stage: one command per go/done handshake, 8-bit full-duplex transfer.
// Optional LSB-first transfers when SPI_LSB_FIRST_EN is defined (adds port lsb_first).
module spi_facade #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [7:0]       command,
  input  logic [7:0]       data_in,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  input  logic             cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output logic             busy,
  output logic             done,
  input  logic             out_fifo_in_full,
  output logic             out_fifo_in_shift,
  output logic [7:0]       out_fifo_in_data,
  output logic             overflow,
  output logic             bp_mosi,
  output logic             bp_clock,
  input  logic             bp_miso,
  output logic             bp_cs
);

  typedef enum logic [2:0] {
    IDLE, HOLD, XFER, PUSH, DONE
  } state_t;

  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W:0]   cnt_q, cnt_d;
  logic [3:0]       half_q, half_d;
  logic [7:0]       tx_q, tx_d, rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic             clk_q, clk_d, mosi_q, mosi_d, cs_q, cs_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             shift_q, shift_d, ovf_q, ovf_d;
  logic             lsb_in, lead, smp;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // edge is leading when the clock is still at its idle level
  assign lead = (clk_q == cpol_q);
  assign smp  = (lead != cpha_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    ovf_d   = ovf_q;
    shift_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_d = cpol_q;
        if (go) begin
          div_d  = clk_div;
          cpol_d = cpol;
          cpha_d = cpha;
          lsb_d  = lsb_in;
          clk_d  = cpol;
          cnt_d  = '0;
          half_d = '0;
          case (command)
            8'h00: begin
              tx_d    = data_in;
              rx_d    = '0;
              mosi_d  = lsb_in ? data_in[0] : data_in[7];
              state_d = XFER;
            end
            8'h01: begin
              cs_d    = 1'b0;
              state_d = HOLD;
            end
            8'h02: begin
              cs_d    = 1'b1;
              state_d = HOLD;
            end
            8'h03: begin
              ovf_d   = 1'b0;
              state_d = DONE;
            end
            default: state_d = DONE;
          endcase
        end
      end
      HOLD: begin
        if (cnt_q == {1'b0, div_q} + ONE) state_d = DONE;
        else cnt_d = cnt_q + ONE;
      end
      XFER: begin
        if (cnt_q == {1'b0, div_q}) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          half_d = half_q + 4'd1;
          if (smp) begin
            rx_d = lsb_q ? {bp_miso, rx_q[7:1]} : {rx_q[6:0], bp_miso};
          end else begin
            if (cpha_q) mosi_d = lsb_q ? tx_q[0] : tx_q[7];
            else mosi_d = lsb_q ? tx_q[1] : tx_q[6];
            tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          end
          if (half_q == 4'd15) begin
            state_d = PUSH;
            if (out_fifo_in_full) begin
              ovf_d = 1'b1;
            end else begin
              shift_d = 1'b1;
              data_d  = rx_d;
            end
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PUSH: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == HOLD) || (state_d == XFER) ||
             (state_d == PUSH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign out_fifo_in_shift = shift_q;
  assign out_fifo_in_data  = data_q;
  assign overflow          = ovf_q;
  assign bp_mosi           = mosi_q;
  assign bp_clock          = clk_q;
  assign bp_cs             = cs_q;

endmodule

// File: tb/tb_spi_facade.sv
// Bench for spi_facade: directed table, randomized commands vs a
// behavioural SPI slave/model, plus re-trigger and async reset sequences.
module tb_spi_facade;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [7:0] command = '0;
  logic [7:0] data_in = '0;
  logic [7:0] clk_div = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic       busy, done;
  logic       full = 1'b0;
  logic       shift;
  logic [7:0] fdata;
  logic       overflow, bp_mosi, bp_clock, bp_cs;
  logic       bp_miso = 1'b0;

  spi_facade #(.DIV_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .go(go),
    .command(command),
    .data_in(data_in),
    .clk_div(clk_div),
    .cpol(cpol),
    .cpha(cpha),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy),
    .done(done),
    .out_fifo_in_full(full),
    .out_fifo_in_shift(shift),
    .out_fifo_in_data(fdata),
    .overflow(overflow),
    .bp_mosi(bp_mosi),
    .bp_clock(bp_clock),
    .bp_miso(bp_miso),
    .bp_cs(bp_cs)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int         div;
    bit         cpol;
    bit         cpha;
    bit         full;
    logic [7:0] miso;
    int         lat;
    bit         cs;
    int         shifts;
    logic [7:0] rx;
    bit         ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  int         r_lat, r_shifts, r_dones, r_tog, r_rise, r_hp_bad;
  logic [7:0] r_rx, r_cap;
  bit         r_busy1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Acts as an SPI slave while observing the handshake.
  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] dat,
                         input int div, input bit cp, input bit ph,
                         input bit fl, input logic [7:0] pat,
                         input int retrig);
    int n, nsamp, last;
    bit prev, leading;
    r_lat = -1; r_shifts = 0; r_dones = 0; r_tog = 0; r_rise = 0;
    r_hp_bad = 0; r_rx = '0; r_cap = '0; r_busy1 = 1'b0;
    command = cmd; data_in = dat; clk_div = div[7:0];
    cpol = cp; cpha = ph; full = fl; bp_miso = pat[7]; go = 1'b1;
    prev = cp; nsamp = 0; last = 0;
    @(posedge clock); #1;
    go = 1'b0;
    command = $urandom; data_in = $urandom; clk_div = $urandom;
    cpol = $urandom; cpha = $urandom;
    n = 1;
    r_busy1 = busy;
    while (r_lat < 0 && n <= 400) begin
      go = (retrig != 0 && n == retrig);
      if (bp_clock != prev) begin
        r_tog++;
        leading = (prev == cp);
        if (bp_clock) r_rise++;
        if (r_tog == 1) begin
          if (n != div + 2) r_hp_bad++;
        end else if (n - last != div + 1) r_hp_bad++;
        last = n;
        if (leading != ph) begin
          r_cap = {r_cap[6:0], bp_mosi};
          nsamp++;
          if (nsamp < 8) bp_miso = pat[7 - nsamp];
        end
        prev = bp_clock;
      end
      if (shift) begin r_shifts++; r_rx = fdata; end
      if (done) begin r_dones++; r_lat = n; end
      if (r_lat < 0) begin @(posedge clock); #1; n++; end
    end
    go = 1'b0;
    if (r_lat < 0) chk("timeout", n, 0);
    repeat (3) begin
      @(posedge clock); #1;
      if (shift) r_shifts++;
      if (done) r_dones++;
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    run_cmd(v.cmd, v.data, v.div, v.cpol, v.cpha, v.full, v.miso, 0);
    chk({tag, " latency"}, r_lat, v.lat);
    chk({tag, " dones"}, r_dones, 1);
    chk({tag, " shifts"}, r_shifts, v.shifts);
    chk({tag, " cs"}, bp_cs, v.cs);
    chk({tag, " overflow"}, overflow, v.ovf);
    chk({tag, " busy"}, r_busy1,
        (v.cmd == 8'h00 || v.cmd == 8'h01 || v.cmd == 8'h02));
    if (v.shifts == 1) chk({tag, " rx"}, r_rx, v.rx);
    if (v.cmd == 8'h00) begin
      chk({tag, " mosi"}, r_cap, v.data);
      chk({tag, " toggles"}, r_tog, 16);
      chk({tag, " rises"}, r_rise, 8);
      chk({tag, " halfper"}, r_hp_bad, 0);
      chk({tag, " idleclk"}, bp_clock, v.cpol);
    end
  endtask

  vec_t tv[11];
  vec_t rv;
  bit   cs_m, ovf_m;
  int   sh_cnt, dn_cnt;

  initial begin
    tv[0]  = '{8'h00, 8'hA5, 0, 0, 0, 0, 8'h3C, 18, 1, 1, 8'h3C, 0};
    tv[1]  = '{8'h00, 8'hFF, 2, 1, 1, 0, 8'h81, 50, 1, 1, 8'h81, 0};
    tv[2]  = '{8'h01, 8'h00, 3, 0, 0, 0, 8'h00, 6, 0, 0, 8'h00, 0};
    tv[3]  = '{8'h02, 8'h00, 3, 0, 0, 0, 8'h00, 6, 1, 0, 8'h00, 0};
    tv[4]  = '{8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0, 0, 8'h00, 0};
    tv[5]  = '{8'h00, 8'h5A, 1, 0, 1, 1, 8'hC3, 34, 0, 0, 8'h00, 1};
    tv[6]  = '{8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0, 0, 8'h00, 1};
    tv[7]  = '{8'h03, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[8]  = '{8'h7F, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[9]  = '{8'h02, 8'h00, 0, 0, 0, 0, 8'h00, 3, 1, 0, 8'h00, 0};
    tv[10] = '{8'h00, 8'h0F, 1, 1, 0, 0, 8'hF0, 34, 1, 1, 8'hF0, 0};

    repeat (2) @(posedge clock);
    #1;
    chk("rst cs", bp_cs, 1);
    chk("rst clk", bp_clock, 0);
    chk("rst mosi", bp_mosi, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst shift", shift, 0);
    chk("rst data", fdata, 0);
    chk("rst ovf", overflow, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), tv[i]);

    cs_m = 1'b1; ovf_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: rv.cmd = 8'h00;
        3: rv.cmd = 8'h01;
        4: rv.cmd = 8'h02;
        5: rv.cmd = 8'h03;
        default: rv.cmd = 8'($urandom_range(4, 255));
      endcase
      rv.data = $urandom; rv.div = $urandom_range(0, 3);
      rv.cpol = $urandom; rv.cpha = $urandom;
      rv.full = ($urandom_range(0, 3) == 0);
      rv.miso = $urandom;
      rv.shifts = 0; rv.rx = rv.miso;
      if (rv.cmd == 8'h00) begin
        rv.lat = 16 * (rv.div + 1) + 2;
        if (rv.full) ovf_m = 1'b1;
        else rv.shifts = 1;
      end else if (rv.cmd == 8'h01 || rv.cmd == 8'h02) begin
        rv.lat = rv.div + 3;
        cs_m = (rv.cmd == 8'h02);
      end else begin
        rv.lat = 1;
        if (rv.cmd == 8'h03) ovf_m = 1'b0;
      end
      rv.cs = cs_m; rv.ovf = ovf_m;
      apply($sformatf("rnd%0d", i), rv);
    end

    run_cmd(8'h00, 8'h96, 0, 0, 0, 0, 8'h69, 3);
    chk("retrig latency", r_lat, 18);
    chk("retrig dones", r_dones, 1);
    chk("retrig shifts", r_shifts, 1);
    chk("retrig rx", r_rx, 8'h69);

    run_cmd(8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    chk("pre-rst cs", bp_cs, 0);
    command = 8'h00; data_in = 8'hC3; clk_div = 8'd3;
    cpol = 1'b1; cpha = 1'b0; full = 1'b0; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    @(posedge clock); #1;
    chk("pre-rst busy", busy, 1);
    chk("pre-rst clk", bp_clock, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst cs", bp_cs, 1);
    chk("arst clk", bp_clock, 0);
    chk("arst busy", busy, 0);
    chk("arst mosi", bp_mosi, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    sh_cnt = 0; dn_cnt = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (shift) sh_cnt++;
      if (done) dn_cnt++;
    end
    chk("post-rst shifts", sh_cnt, 0);
    chk("post-rst dones", dn_cnt, 0);
    chk("post-rst ovf", overflow, 0);
    run_cmd(8'h55, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    chk("post-rst nop latency", r_lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_facade.md
Name: spi_facade

Overview:
- SPI peripheral stage directly downstream of the command dispatcher.
- Accepts one opcode/data byte per go/done handshake, drives chip select and one full-duplex 8-bit SPI byte transfer, and pushes each received byte into the output FIFO.
- Clock polarity, clock phase and clock divider are per-command configuration inputs, latched at go.

Parameters:
- DIV_W, 8, width of clk_div; SPI half-period = clk_div+1 system clocks.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  start pulse; sampled only in IDLE
- command  in  8  opcode: 0x00 transfer byte, 0x01 CS assert, 0x02 CS deassert, 0x03 clear status
- data_in  in  8  byte to transmit for 0x00
- clk_div  in  DIV_W  half-period minus one
- cpol  in  1  idle clock level
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- busy  out  1  high from the cycle after go is accepted until done
- done  out  1  one-cycle completion pulse
- out_fifo_in_full  in  1  output FIFO full
- out_fifo_in_shift  out  1  one-cycle push strobe
- out_fifo_in_data  out  8  received byte
- overflow  out  1  sticky: received byte dropped because the FIFO was full
- bp_mosi  out  1  master out
- bp_clock  out  1  SPI clock
- bp_miso  in  1  master in
- bp_cs  out  1  chip select, active-low

Behaviour:
- Reset values: bp_cs=1, bp_clock=0, bp_mosi=0, busy=0, done=0, out_fifo_in_shift=0, out_fifo_in_data=0, overflow=0; latched cpol/cpha/div=0; state IDLE.
- Reset mid-operation aborts immediately: no push, no done, CS released.
- States: IDLE, HOLD, XFER, PUSH, DONE.
- IDLE:
  - bp_clock = latched cpol.
  - On go: latch command, data_in, clk_div, cpol, cpha.
  - 0x00 -> XFER. 0x01 -> set bp_cs=0, go to HOLD. 0x02 -> set bp_cs=1, go to HOLD.
  - 0x03 -> clear overflow, go to DONE. Any other opcode -> DONE (no-op).
- HOLD: wait clk_div+1 cycles (CS setup/hold guard), then DONE.
- XFER:
  - 16 half-periods, each clk_div+1 cycles; bp_clock toggles at every half-period boundary.
  - Bit order: MSB first.
  - cpha=0: bp_mosi presents bit 7 on entry to XFER; bp_miso is sampled at each leading edge; the next bit shifts out at each trailing edge.
  - cpha=1: bp_mosi changes at each leading edge; bp_miso is sampled at each trailing edge.
  - bp_clock ends at cpol. Then go to PUSH.
- PUSH (1 cycle):
  - If !out_fifo_in_full: out_fifo_in_shift=1 with the received byte on out_fifo_in_data.
  - Else: overflow<=1 and the byte is discarded.
  - Then DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. A new go is accepted on the next IDLE cycle.
- Latency, measured from the edge sampling go to done high:
  - 0x00: 16*(clk_div+1)+2 cycles.
  - 0x01/0x02: clk_div+3 cycles.
  - other opcodes: 1 cycle.
- go while busy or in DONE is ignored (not queued).
- Config inputs changing during a command have no effect until the next go.
- bp_cs persists across commands; 0x00 does not touch CS.
- Overflow set and clear (0x03) in the same cycle cannot occur: a single command is executed at a time.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- With it defined: adds input port lsb_first (1 bit), latched at go. When the latched value is 1, transmit and receive are LSB first; otherwise MSB first.
- Without it: no lsb_first port, and transfers are always MSB first.

Test Plan:
- Mode 0, clk_div=0: go 0x00/0xA5 with bp_miso driven 0x3C MSB first -> bp_mosi bits 1,0,1,0,0,1,0,1; 8 rising edges; out_fifo_in_shift once with data 0x3C; done 18 cycles after go.
- Mode 3 (cpol=1, cpha=1), clk_div=2: go 0x00/0xFF, bp_miso=0x81 -> bp_clock idles high; each half-period is 3 cycles; received 0x81; done at cycle 50.
- go 0x01, clk_div=3 -> bp_cs=0 the next cycle, done at cycle 6; go 0x02 -> bp_cs=1, done at cycle 6.
- out_fifo_in_full=1 during 0x00 -> no shift, overflow=1 and it stays set across a further 0x01; go 0x03 -> overflow=0, done 1 cycle later.
- go pulsed again 3 cycles into a 0x00 transfer -> ignored; exactly one done and one shift.
- Reset asserted mid-XFER -> asynchronously bp_cs=1, bp_clock=0, busy=0; no shift and no done afterwards.
